carry_lookahead_16bit: RTL and testbench

16-bit two-level carry-lookahead adder computing sum = a + b + cin with carry-out, using output registers.
- Four 4-bit lookahead groups plus a second-level carry unit.
- Registered outputs give a clean one-cycle-latency arithmetic primitive for datapath use (ALU, address generation).
- No ripple path across groups.

---
 rtl/cla_pkg.sv | 8 +
 rtl/cla_group4.sv | 42 ++++
 rtl/carry_lookahead_16bit.sv | 80 ++++++++
 tb/tb_carry_lookahead_16bit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants for the 16-bit two-level carry-lookahead adder
package cla_pkg;

    localparam int WIDTH      = 16;
    localparam int GROUP      = 4;
    localparam int NUM_GROUPS = WIDTH / GROUP;

endpackage : cla_pkg

// File: rtl/cla_group4.sv
// rtl/cla_group4.sv - 4-bit lookahead group: sum bits plus group generate/propagate
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             gg,
    output logic             gp
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each internal carry is a flat sum of products of g/p and c_in, never chained.
    always_comb begin
        c[0] = c_in;
        c[1] = g[0]
             | (p[0] & c_in);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c_in);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
    end

    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

    assign s = p ^ c;

endmodule : cla_group4

// File: rtl/carry_lookahead_16bit.sv
// rtl/carry_lookahead_16bit.sv - registered 16-bit two-level carry-lookahead adder
module carry_lookahead_16bit
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [NUM_GROUPS-1:0] gg;
    logic [NUM_GROUPS-1:0] gp;
    logic [NUM_GROUPS-1:0] grp_cin;
    logic                  c4;
    logic                  c8;
    logic                  c12;
    logic                  c16;

    logic [WIDTH-1:0]      sum_d;
    logic [WIDTH-1:0]      sum_q;
    logic                  cout_d;
    logic                  cout_q;
    logic                  valid_d;
    logic                  valid_q;

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
        cla_group4 u_grp (
            .a    (a[k*GROUP +: GROUP]),
            .b    (b[k*GROUP +: GROUP]),
            .c_in (grp_cin[k]),
            .s    (sum_d[k*GROUP +: GROUP]),
            .gg   (gg[k]),
            .gp   (gp[k])
        );
    end

    // Second-level carries: each one depends only on GG/GP and cin.
    assign c4  = gg[0]
               | (gp[0] & cin);
    assign c8  = gg[1]
               | (gp[1] & gg[0])
               | (gp[1] & gp[0] & cin);
    assign c12 = gg[2]
               | (gp[2] & gg[1])
               | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
    assign c16 = gg[3]
               | (gp[3] & gg[2])
               | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    assign grp_cin = {c12, c8, c4, cin};

    assign cout_d  = c16;
    assign valid_d = in_valid;

    // Capture every cycle; in_valid only qualifies the result, it never gates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule : carry_lookahead_16bit

// File: tb/tb_carry_lookahead_16bit.sv
// tb/tb_carry_lookahead_16bit.sv - self-checking bench for carry_lookahead_16bit
module tb_carry_lookahead_16bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;

    int checks;
    int errors;

    carry_lookahead_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
        int unsigned total;
        total = int'(x) + int'(y) + int'(ci);
        return total[16:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " sum"},   32'(sum),       32'h0);
        chk({tag, " cout"},  32'(cout),      32'h0);
        chk({tag, " valid"}, 32'(out_valid), 32'h0);
    endtask

    // Present operands, take one edge, then compare the captured result.
    task automatic step(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic tv, input logic [16:0] exp, input string tag);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = tv;
        @(posedge clk);
        #1;
        chk({tag, " sum"},   32'(sum),       32'(exp[15:0]));
        chk({tag, " cout"},  32'(cout),      32'(exp[16]));
        chk({tag, " valid"}, 32'(out_valid), 32'(tv));
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rv;

        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        #2 rst_n = 1'b0;
        #1 chk_zero("reset_async");

        for (int i = 0; i < 3; i++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1 chk_zero("reset_held");
        end
        rst_n = 1'b1;

        step(16'd0,     16'd0,     1'b0, 1'b1, 17'h00000, "zero");
        step(16'd0,     16'd0,     1'b1, 1'b1, 17'h00001, "cin_only");
        step(16'd14,    16'd1,     1'b1, 1'b1, 17'h00010, "small_16");
        step(16'd5,     16'd0,     1'b0, 1'b1, 17'h00005, "small_5");
        step(16'd999,   16'd0,     1'b1, 1'b1, 17'd1000,  "small_1000");
        step(16'hFFFF,  16'h0000,  1'b1, 1'b1, 17'h10000, "wrap");
        step(16'h00FF,  16'h0001,  1'b0, 1'b1, 17'h00100, "carry_byte");
        step(16'h0FFF,  16'h0001,  1'b0, 1'b1, 17'h01000, "carry_groups");
        step(16'hFFFF,  16'hFFFF,  1'b1, 1'b1, 17'h1FFFF, "max");
        step(16'h8000,  16'h8000,  1'b0, 1'b1, 17'h10000, "msb_pair");

        step(16'h1234,  16'h4321,  1'b0, 1'b1, 17'h05555, "valid_1");
        step(16'hA5A5,  16'h5A5A,  1'b1, 1'b0, 17'h10000, "valid_0");
        step(16'h7FFF,  16'h0001,  1'b0, 1'b1, 17'h08000, "valid_1b");

        // Reset between two edges while a nonzero result is on the outputs.
        step(16'h1234,  16'h1111,  1'b0, 1'b1, 17'h02345, "pre_reset");
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_mid");
        a        = 16'd7;
        b        = 16'd8;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        chk_zero("reset_mid_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset sum",   32'(sum),       32'd15);
        chk("post_reset cout",  32'(cout),      32'd0);
        chk("post_reset valid", 32'(out_valid), 32'd1);

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rv = 1'($urandom);
            step(ra, rb, rc, rv, ref_add(ra, rb, rc), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_carry_lookahead_16bit
